// File: rtl/div_pkg.sv
// Shared definitions for the byte-serial divider arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PULL    = 3'd3,
        ST_RECOVER = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Operand bytes pushed (4 dividend + 4 divisor) and result bytes pulled.
    localparam int BYTE_CNT = 8;

    // Cycles the divider is held in reset after a timeout.
    localparam int RECOVER_CYCLES = 2;

endpackage

// File: rtl/div_rr_arbiter.sv
// Round-robin grant: lowest valid index at or above ptr, wrapping to index 0.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own ready.
module div_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    grant_idx,
    output logic             grant_any
);

    // Two passes: first search from ptr upward, then wrap to the low indices.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && valid[i] && (PW'(i) >= ptr)) begin
                grant_any = 1'b1;
                grant_idx = PW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && valid[i]) begin
                grant_any = 1'b1;
                grant_idx = PW'(i);
            end
        end
        grant = grant_any ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one byte-serial divider among N_REQ requesters, one operation in flight.
// Latency: response valid 17 cycles after the handshake cycle when the divider answers at once.
// Backpressure: req_ready only in IDLE; result held in RESP until the owner's rsp_ready.
module div_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_mode,
    input  logic [N_REQ-1:0]     req_sign,
    input  logic [32*N_REQ-1:0]  req_z,
    input  logic [32*N_REQ-1:0]  req_d,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [63:0]          rsp_data,
    output logic                 rsp_sign,
    output logic                 rsp_err,
    output logic                 div_push,
    output logic [7:0]           div_data_in,
    output logic                 div_sign,
    output logic                 div_select,
    input  logic                 div_pull,
    input  logic [7:0]           div_data_out,
    input  logic                 div_sign_out,
    output logic                 div_rst_n
);
    import div_pkg::*;

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Counter must hold both the byte index and the WAIT timeout.
    localparam int CW = (TIMEOUT > BYTE_CNT) ? $clog2(TIMEOUT) : $clog2(BYTE_CNT);

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [CW-1:0]     cnt;
    logic [63:0]       shreg;

    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     grant_idx;
    logic              grant_any;

    logic [31:0]       z_sel;
    logic [31:0]       d_sel;
    logic              mode_sel;
    logic              sign_sel;
    logic              handshake;

    div_rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Ready is offered only while idle, and never while reset is held.
    assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
    assign handshake = grant_any && ((req_valid & req_ready) != '0);

    // Select the granted requester's operands (one-hot grant, so OR-free mux).
    always_comb begin
        z_sel    = '0;
        d_sel    = '0;
        mode_sel = 1'b0;
        sign_sel = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                z_sel    = req_z[32*i +: 32];
                d_sel    = req_d[32*i +: 32];
                mode_sel = req_mode[i];
                sign_sel = req_sign[i];
            end
        end
    end

    // Main controller: grant, push operands, await result, pull or recover, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            cnt         <= '0;
            shreg       <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_sign    <= 1'b0;
            rsp_err     <= 1'b0;
            div_push    <= 1'b0;
            div_data_in <= '0;
            div_sign    <= 1'b0;
            div_select  <= 1'b0;
            div_rst_n   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        owner       <= grant_idx;
                        // First byte goes out in the first PUSH cycle; the rest queue behind it.
                        div_data_in <= z_sel[31:24];
                        shreg       <= {z_sel[23:0], d_sel, 8'h00};
                        div_push    <= 1'b1;
                        div_sign    <= sign_sel;
                        div_select  <= mode_sel;
                        cnt         <= '0;
                        state       <= ST_PUSH;
                    end
                end

                ST_PUSH: begin
                    if (cnt == CW'(BYTE_CNT - 1)) begin
                        div_push    <= 1'b0;
                        div_data_in <= '0;
                        cnt         <= '0;
                        state       <= ST_WAIT;
                    end else begin
                        div_data_in <= shreg[63:56];
                        shreg       <= {shreg[55:0], 8'h00};
                        cnt         <= cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (div_pull) begin
                        rsp_data <= {56'd0, div_data_out};
                        rsp_sign <= div_sign_out;
                        cnt      <= CW'(1);
                        state    <= ST_PULL;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        div_rst_n <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_RECOVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_PULL: begin
                    // Bytes arrive LSB first on consecutive cycles; div_pull is not consulted.
                    for (int b = 1; b < BYTE_CNT; b++) begin
                        if (cnt == CW'(b)) begin
                            rsp_data[8*b +: 8] <= div_data_out;
                        end
                    end
                    if (cnt == CW'(BYTE_CNT - 1)) begin
                        rsp_valid  <= N_REQ'(1) << owner;
                        div_sign   <= 1'b0;
                        div_select <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RECOVER: begin
                    if (cnt == CW'(RECOVER_CYCLES - 1)) begin
                        div_rst_n  <= 1'b1;
                        rsp_valid  <= N_REQ'(1) << owner;
                        div_sign   <= 1'b0;
                        div_select <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if ((rsp_valid & rsp_ready) != '0) begin
                        rsp_valid <= '0;
                        rsp_err   <= 1'b0;
                        rr_ptr    <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: vector table, corner sequences, random ops.
// Latency: checks cycle-exact push/pull/timeout timing against a behavioural model.
// Backpressure: exercises held rsp_ready and concurrent requesters.
module tb_div_arbiter;

    localparam int N  = 2;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_mode = '0;
    logic [1:0]  req_sign = '0;
    logic [1:0]  rsp_ready = '0;
    logic [63:0] req_z = '0;
    logic [63:0] req_d = '0;
    logic        div_pull = 1'b0;
    logic [7:0]  div_data_out = '0;
    logic        div_sign_out = 1'b0;

    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_sign;
    logic        rsp_err;
    logic        div_push;
    logic [7:0]  div_data_in;
    logic        div_sign;
    logic        div_select;
    logic        div_rst_n;

    int n_chk = 0;
    int n_fail = 0;
    int exp_ptr = 0;

    div_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .req_sign     (req_sign),
        .req_z        (req_z),
        .req_d        (req_d),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_sign     (rsp_sign),
        .rsp_err      (rsp_err),
        .div_push     (div_push),
        .div_data_in  (div_data_in),
        .div_sign     (div_sign),
        .div_select   (div_select),
        .div_pull     (div_pull),
        .div_data_out (div_data_out),
        .div_sign_out (div_sign_out),
        .div_rst_n    (div_rst_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [31:0] z;
        logic [31:0] d;
        logic        mode;
        logic        sign;
        int          delay;   // cycles before the divider answers; -1 = never
        logic [63:0] res;     // value the divider returns = expected rsp_data
        logic        sgo;     // divider sign output = expected rsp_sign
        bit          glitch;  // stray div_pull during PUSH
        int          hold;    // cycles rsp_ready is withheld
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first valid index at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [1:0] v, input int p);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, " outs"},
            {req_ready, rsp_valid, rsp_sign, rsp_err, div_push, div_data_in, div_sign, div_select, div_rst_n},
            {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        chk({tag, " data"}, rsp_data, 64'h0);
    endtask

    task automatic set_req(input int who, input logic [31:0] z, input logic [31:0] d,
                           input logic m, input logic s);
        req_z[32*who +: 32] = z;
        req_d[32*who +: 32] = d;
        req_mode[who]       = m;
        req_sign[who]       = s;
    endtask

    // One complete operation; called at posedge+1 with req_valid already set.
    task automatic run_op(input int delay, input logic [63:0] res, input logic sgo,
                          input bit glitch, input int hold, input bit keep);
        int          exp_who;
        int          waited;
        int          low;
        logic [63:0] zd;
        logic [63:0] exp_data;
        logic [63:0] held;
        logic        m;
        logic        s;

        exp_who = rr_pick(req_valid, exp_ptr);
        waited  = 0;
        #1;
        while ((req_valid & req_ready) == 2'b00 && waited < 50) begin
            tick();
            #1;
            waited++;
        end
        chk("req_ready grant", req_ready, 2'b01 << exp_who);
        if ((req_valid & req_ready) == 2'b00) return;

        zd = {req_z[32*exp_who +: 32], req_d[32*exp_who +: 32]};
        m  = req_mode[exp_who];
        s  = req_sign[exp_who];
        tick();
        if (!keep) req_valid[exp_who] = 1'b0;

        for (int k = 0; k < 8; k++) begin
            chk("push valid", div_push, 1'b1);
            chk("push byte", div_data_in, zd[63-8*k -: 8]);
            chk("push ctl", {div_select, div_sign}, {m, s});
            chk("req_ready busy", req_ready, 2'b00);
            if (glitch && k == 2) begin
                div_pull     = 1'b1;
                div_data_out = 8'hEE;
            end
            tick();
            div_pull = 1'b0;
        end
        chk("push end", div_push, 1'b0);
        chk("wait ctl", {div_select, div_sign}, {m, s});

        if (delay >= 0) begin
            for (int w = 0; w < delay; w++) begin
                chk("wait div_rst_n", div_rst_n, 1'b1);
                tick();
            end
            div_pull     = 1'b1;
            div_data_out = res[7:0];
            div_sign_out = sgo;
            tick();
            div_sign_out = ~sgo;
            for (int b = 1; b < 8; b++) begin
                chk("pull ctl", {div_select, div_sign}, {m, s});
                div_pull     = 1'($urandom_range(0, 1));
                div_data_out = res[8*b +: 8];
                tick();
            end
            div_pull     = 1'b0;
            div_data_out = '0;
            exp_data     = res;
            chk("rsp_err", rsp_err, 1'b0);
            chk("rsp_sign", rsp_sign, sgo);
        end else begin
            waited = 0;
            while (div_rst_n === 1'b1 && waited < 200) begin
                tick();
                waited++;
            end
            chk("timeout cycles", waited, TO);
            low = 0;
            while (div_rst_n === 1'b0 && low < 10) begin
                tick();
                low++;
            end
            chk("div_rst_n low cycles", low, 2);
            chk("rsp_err", rsp_err, 1'b1);
            exp_data = 64'h0;
        end

        chk("rsp_valid", rsp_valid, 2'b01 << exp_who);
        chk("rsp_data", rsp_data, exp_data);
        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold rsp_valid", rsp_valid, 2'b01 << exp_who);
            chk("hold rsp_data", rsp_data, held);
            chk("hold req_ready", req_ready, 2'b00);
        end
        rsp_ready[exp_who] = 1'b1;
        tick();
        rsp_ready = '0;
        chk("rsp retire", {rsp_valid, rsp_err}, 3'b000);
        exp_ptr = (exp_who + 1) % N;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 32'h4f800000, 32'h3f800000, 1'b1, 1'b0, 0,  64'h0123456789abcdef, 1'b0, 1'b0, 0};
        vecs[1] = '{1, 32'hdeadbeef, 32'h00000007, 1'b0, 1'b1, 3,  64'hfedcba9876543210, 1'b1, 1'b0, 2};
        vecs[2] = '{0, 32'h80000000, 32'hffffffff, 1'b0, 1'b1, 0,  64'h1122334455667788, 1'b1, 1'b1, 1};
        vecs[3] = '{1, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 7,  64'hffffffffffffffff, 1'b0, 1'b0, 0};
        vecs[4] = '{0, 32'h12345678, 32'h9abcdef0, 1'b1, 1'b1, -1, 64'h0,                1'b0, 1'b0, 3};
        vecs[5] = '{1, 32'h7f7fffff, 32'h00800000, 1'b1, 1'b0, 1,  64'ha5a5a5a55a5a5a5a, 1'b1, 1'b1, 0};

        // Power-on reset.
        #2 rst_n = 1'b0;
        tick();
        tick();
        check_reset_vals("por");
        rst_n = 1'b1;
        tick();

        // Both requesters valid from reset: grants must alternate 0,1,0,1.
        set_req(0, 32'h40490fdb, 32'h40000000, 1'b1, 1'b0);
        set_req(1, 32'h00000064, 32'h00000005, 1'b0, 1'b1);
        req_valid = 2'b11;
        run_op(0, 64'h0000000000000014, 1'b0, 1'b0, 10, 1'b1);
        run_op(0, 64'h3fc90fdb00000000, 1'b1, 1'b0, 0,  1'b1);
        run_op(2, 64'h00000000deadbeef, 1'b0, 1'b0, 1,  1'b1);
        run_op(0, 64'h8000000000000001, 1'b1, 1'b0, 0,  1'b1);
        req_valid = '0;
        tick();

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            set_req(vecs[v].who, vecs[v].z, vecs[v].d, vecs[v].mode, vecs[v].sign);
            req_valid = '0;
            req_valid[vecs[v].who] = 1'b1;
            run_op(vecs[v].delay, vecs[v].res, vecs[v].sgo, vecs[v].glitch, vecs[v].hold, 1'b0);
        end
        tick();

        // Reset in the fifth PUSH cycle abandons the operation.
        set_req(0, 32'h11223344, 32'h55667788, 1'b0, 1'b1);
        req_valid = 2'b01;
        #1;
        chk("midrst req_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        repeat (4) tick();
        chk("midrst push5 byte", div_data_in, 8'h55);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        tick();
        rst_n   = 1'b1;
        exp_ptr = 0;
        for (int c = 0; c < 3; c++) begin
            chk("post-reset idle", {rsp_valid, div_push}, 3'b000);
            tick();
        end
        set_req(0, 32'hcafef00d, 32'h0badc0de, 1'b1, 1'b0);
        req_valid = 2'b01;
        run_op(0, 64'h0f1e2d3c4b5a6978, 1'b1, 1'b0, 0, 1'b0);

        // Random operations.
        for (int r = 0; r < 12; r++) begin
            set_req(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_req(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            req_valid = 2'($urandom_range(1, 3));
            run_op($urandom_range(0, 4), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters sharing one byte-serial divider.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for div_pull after the last pushed byte.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  N_REQ  per-requester accept; handshake = valid&ready.
REQ-007 SHALL have port req_mode  input  N_REQ  per-requester select (0 radix-2 integer, 1 fp32).
REQ-008 SHALL have port req_sign  input  N_REQ  per-requester signed flag.
REQ-009 SHALL have port req_z  input  32*N_REQ  dividend, requester i at [32i+31:32i].
REQ-010 SHALL have port req_d  input  32*N_REQ  divisor, same packing.
REQ-011 SHALL have port rsp_valid  output  N_REQ  one-hot result valid to owning requester.
REQ-012 SHALL have port rsp_ready  input  N_REQ  per-requester result accept.
REQ-013 SHALL have port rsp_data  output  64  result word (shared).
REQ-014 SHALL have port rsp_sign  output  1  captured div_sign_out.
REQ-015 SHALL have port rsp_err  output  1  1 = timeout, rsp_data = 0.
REQ-016 SHALL have port div_push, div_data_in[7:0], div_sign, div_select  outputs  divider input side.
REQ-017 SHALL have port div_pull, div_data_out[7:0], div_sign_out  inputs  divider output side.
REQ-018 SHALL have port div_rst_n  output  1  active-low divider reset used for timeout recovery.

Function
REQ-019 SHALL implement FSM IDLE, PUSH, WAIT, PULL, RECOVER, RESP.
REQ-020 SHALL in IDLE grant round-robin: lowest index >= rr_ptr with req_valid, wrapping; req_ready[i] high only for granted i and only in IDLE (combinational).
REQ-021 SHALL on handshake latch owner, z, d, mode, sign; next state PUSH.
REQ-022 SHALL in PUSH assert div_push for exactly 8 consecutive cycles, bytes z[31:24], z[23:16], z[15:8], z[7:0], d[31:24], d[23:16], d[15:8], d[7:0]; first byte in the first PUSH cycle.
REQ-023 SHALL hold div_sign and div_select at latched values from first PUSH cycle through end of PULL.
REQ-024 SHALL in WAIT count cycles from 0; div_pull=1 captures div_data_out into rsp_data[7:0] and div_sign_out into rsp_sign, next PULL.
REQ-025 SHALL in PULL capture 7 further bytes on consecutive cycles into [15:8]..[63:56] (LSB byte first), then RESP; div_pull during PULL ignored.
REQ-026 SHALL, if counter reaches TIMEOUT-1 without div_pull, enter RECOVER: div_rst_n=0 for 2 cycles, rsp_data=0, rsp_err=1, then RESP.
REQ-027 SHALL ignore div_pull in IDLE, PUSH, RECOVER, RESP.
REQ-028 SHALL in RESP hold rsp_valid[owner]=1 with stable data until rsp_ready[owner]; then rr_ptr=(owner+1) mod N_REQ, clear rsp_err, go IDLE.
REQ-029 SHALL give minimum request-to-response latency 1+8+0+8 = 17 cycles after handshake (pull in first WAIT cycle).
REQ-030 SHALL never accept a new request outside IDLE (one operation in flight).

Reset
REQ-031 SHALL on rst_n=0 asynchronously: state IDLE, rr_ptr 0, counters 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_sign 0, rsp_err 0, div_push 0, div_data_in 0, div_sign 0, div_select 0, div_rst_n 1.
REQ-032 SHALL on reset mid-operation abandon the operation with no response; no partial result persists.

Structure
REQ-033 SHALL place FSM state encoding and byte count constant (8) in a shared package div_pkg.
REQ-034 SHALL use one sub-module div_rr_arbiter (N_REQ-wide round-robin grant from valid and rr_ptr).

Verification
REQ-035 SHALL cover: req0 z=0x4f800000, d=0x3f800000, mode=1 -> div_data_in 4f,80,00,00,3f,80,00,00 on 8 push cycles; model pull returns 0x0123456789abcdef LSB first -> rsp_data=0x0123456789abcdef, rsp_valid=01.
REQ-036 SHALL cover: req0 and req1 valid together from reset -> grant order 0,1,0,1 over four ops.
REQ-037 SHALL cover: model never pulls, TIMEOUT=64 -> div_rst_n low exactly 2 cycles, rsp_err=1, rsp_data=0.
REQ-038 SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable, req_ready stays 0.
REQ-039 SHALL cover: rst_n asserted in 5th PUSH cycle -> all outputs reset values, next request pushes from byte 0.
REQ-040 SHALL cover: div_pull pulse during PUSH -> ignored, result still captured from later pull.
